div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider serving the execute stage for DIV/DIVU. Execute asserts `start` with operands. The divider raises `arith_stall` while it iterates. It then presents the remainder/quotient for one cycle with `div_valid`, so execute can forward them to HI/LO alongside `whilo_out`. Sits beside execute as its arithmetic responder, between ID/EX operands and the HI/LO register file.

---
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider for DIV/DIVU with signed fixup and divide-by-zero handling.
// Optional macro DIV_EARLY_OUT_EN finishes at once when |dividend| < |divisor|.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic        arith_stall,
    output logic        div_valid,
    output logic [31:0] div_hi,
    output logic [31:0] div_lo,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d, neg_q, neg_d, dneg_q, dneg_d, dbz_q, dbz_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, hi_q, hi_d, lo_q, lo_d;
    logic [31:0] dvd_mag, dsr_mag, rem_n, quo_n;
    logic [32:0] sh, diff;
    logic        accept, early;

    assign dvd_mag = (signed_div && dividend[31]) ? -dividend : dividend;
    assign dsr_mag = (signed_div && divisor[31]) ? -divisor : divisor;
    assign accept  = state_q == IDLE && start && !annul;
`ifdef DIV_EARLY_OUT_EN
    assign early = dvd_mag < dsr_mag;
`else
    assign early = 1'b0;
`endif
    // One restoring step: shift {rem,quo} left, subtract divisor when it fits
    assign sh    = {rem_q, quo_q[31]};
    assign diff  = sh - {1'b0, dsr_q};
    assign rem_n = diff[32] ? sh[31:0] : diff[31:0];
    assign quo_n = {quo_q[30:0], ~diff[32]};

    assign arith_stall = (accept && divisor != 32'd0) || state_q == DIV;
    assign div_valid   = state_q == DONE;
    assign div_hi      = hi_q;
    assign div_lo      = lo_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        dneg_d  = dneg_q;
        dbz_d   = dbz_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (accept) begin
                sgn_d   = signed_div;
                neg_d   = signed_div && dividend[31];
                dneg_d  = signed_div && divisor[31];
                dbz_d   = divisor == 32'd0;
                rem_d   = 32'd0;
                quo_d   = dvd_mag;
                dsr_d   = dsr_mag;
                cnt_d   = 5'd0;
                state_d = (divisor == 32'd0 || early) ? DONE : DIV;
                hi_d    = (divisor == 32'd0 || early) ? dividend : hi_q;
                lo_d    = divisor == 32'd0 ? 32'hFFFF_FFFF : early ? 32'd0 : lo_q;
            end
            DIV: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    lo_d    = (sgn_q && (neg_q ^ dneg_q)) ? -quo_n : quo_n;
                    hi_d    = neg_q ? -rem_n : rem_n;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (annul) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            dneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dsr_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            dneg_q  <= dneg_d;
            dbz_q   <= dbz_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expected results come from plain integer division.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, signed_div, annul;
    logic [31:0] dividend, divisor;
    logic        arith_stall, div_valid, div_by_zero;
    logic [31:0] div_hi, div_lo;
    int          total = 0, bad = 0, cyc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    div_unit dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .dividend(dividend), .divisor(divisor), .annul(annul),
        .arith_stall(arith_stall), .div_valid(div_valid), .div_hi(div_hi),
        .div_lo(div_lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                  output exp_t e, output int lat);
        longint sa, sb2, q, r;
        e.dbz = (b == 32'd0);
        lat   = 33;
        if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            lat  = 1;
            return;
        end
        sa   = sd ? longint'($signed(a)) : longint'(a);
        sb2  = sd ? longint'($signed(b)) : longint'(b);
        q    = sa / sb2;
        r    = sa % sb2;
        e.lo = q[31:0];
        e.hi = r[31:0];
`ifdef DIV_EARLY_OUT_EN
        if ((sa < 0 ? -sa : sa) < (sb2 < 0 ? -sb2 : sb2)) lat = 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && div_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("div_lo", {32'd0, div_lo}, {32'd0, e.lo});
                chk("div_hi", {32'd0, div_hi}, {32'd0, e.hi});
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                chk("valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input bit sd, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        model(sd, a, b, e, lat);
        @(negedge clk);
        start = 1'b1; signed_div = sd; dividend = a; divisor = b;
        #1 chk("stall_c0", {63'd0, arith_stall}, {63'd0, b != 32'd0});
        e.cyc = cyc + lat;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        dividend = $urandom; divisor = $urandom; signed_div = $urandom_range(0, 1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("stall_run", {63'd0, arith_stall}, {63'd0, k < lat});
        end
        #1;
        if (sb.size() != 0) begin
            chk("missing_valid", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] a, b, ph, pl;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", {32'd0, div_hi}, 64'd0);
        chk("rst_lo", {32'd0, div_lo}, 64'd0);
        chk("rst_valid", {63'd0, div_valid}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_stall", {63'd0, arith_stall}, 64'd0);
        rst = 1'b0;
        issue(1'b0, 32'd100, 32'd7);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 32'd5, 32'd0);
        issue(1'b1, 32'hFFFF_FFFB, 32'd0);
        issue(1'b0, 32'd3, 32'd9);
        issue(1'b1, 32'hFFFF_FFFD, 32'd9);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        // annul at cycle 10 of 100/7, then a fresh start in cycle 12
        ph = div_hi; pl = div_lo;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        @(negedge clk);
        chk("annul_stall", {63'd0, arith_stall}, 64'd0);
        chk("annul_hi", {32'd0, div_hi}, {32'd0, ph});
        chk("annul_lo", {32'd0, div_lo}, {32'd0, pl});
        issue(1'b0, 32'd1000, 32'd13);
        // reset in cycle 15 of an operation
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; dividend = 32'd12345; divisor = 32'd11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_hi", {32'd0, div_hi}, 64'd0);
        chk("mid_rst_lo", {32'd0, div_lo}, 64'd0);
        chk("mid_rst_valid", {63'd0, div_valid}, 64'd0);
        chk("mid_rst_stall", {63'd0, arith_stall}, 64'd0);
        rst = 1'b0;
        issue(1'b0, 32'd77, 32'd0);
        issue(1'b0, 32'd100, 32'd7);
        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 50)) : $urandom;
            b = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 100)) : $urandom;
            issue(1'($urandom_range(0, 1)), a, b);
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
